// File: rtl/dline_tap_ctrl.sv
// Delay-line tap calibration controller: sweeps taps upward, settles, majority-votes
// phase-detector samples and locks on the first non-early tap. Define DLINE_TRACK_EN to make DONE track.
module dline_tap_ctrl #(
  parameter int TAP_W      = 5,
  parameter int SETTLE_CYC = 8,
  parameter int NSAMP      = 7,
  parameter int START_TAP  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cal_start,
  input  logic             pd_valid,
  input  logic             pd_early,
  output logic [TAP_W-1:0] tap_sel,
  output logic             cal_busy,
  output logic             cal_done,
  output logic             cal_fail,
  output logic [TAP_W-1:0] lock_tap
);

  localparam int SC_W = $clog2(SETTLE_CYC + 1);
  localparam int SN_W = $clog2(NSAMP + 1);
  localparam logic [TAP_W-1:0] TAP_MAX     = {TAP_W{1'b1}};
  localparam logic [TAP_W-1:0] TAP_START   = TAP_W'(START_TAP);
  localparam logic [SC_W-1:0]  SETTLE_LAST = SC_W'(SETTLE_CYC - 1);
  localparam logic [SN_W-1:0]  NSAMP_V     = SN_W'(NSAMP);
  localparam logic [SN_W-1:0]  HALF_V      = SN_W'(NSAMP / 2);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_STEP   = 3'd3,
    ST_DONE   = 3'd4,
    ST_FAIL   = 3'd5
  } state_t;

  state_t           state_r, state_s;
  logic [TAP_W-1:0] tap_r, tap_s;
  logic [TAP_W-1:0] lock_r, lock_s;
  logic [SC_W-1:0]  setl_r, setl_s;
  logic [SN_W-1:0]  scnt_r, scnt_s;
  logic [SN_W-1:0]  ecnt_r, ecnt_s;
  logic             busy_r, done_r, fail_r;
`ifdef DLINE_TRACK_EN
  localparam logic [SC_W-1:0] SETTLE_V = SC_W'(SETTLE_CYC);
  logic [SC_W-1:0]  trk_r, trk_s;
`endif

  // Next-state, tap and counter computation
  always_comb begin
    state_s = state_r;
    tap_s   = tap_r;
    lock_s  = lock_r;
    setl_s  = setl_r;
    scnt_s  = scnt_r;
    ecnt_s  = ecnt_r;
`ifdef DLINE_TRACK_EN
    trk_s   = trk_r;
`endif
    case (state_r)
      ST_IDLE, ST_FAIL: begin
        if (cal_start) begin
          state_s = ST_SETTLE;
          tap_s   = TAP_START;
          setl_s  = '0;
        end else begin
          state_s = state_r;
        end
      end
      ST_SETTLE: begin
        if (setl_r == SETTLE_LAST) begin
          state_s = ST_SAMPLE;
          scnt_s  = '0;
          ecnt_s  = '0;
        end else begin
          setl_s  = setl_r + 1'b1;
        end
      end
      ST_SAMPLE: begin
        if (scnt_r == NSAMP_V) begin
          state_s = ST_STEP;
        end else if (pd_valid) begin
          scnt_s  = scnt_r + 1'b1;
          ecnt_s  = ecnt_r + SN_W'(pd_early);
        end else begin
          scnt_s  = scnt_r;
        end
      end
      ST_STEP: begin
        if (ecnt_r > HALF_V) begin
          if (tap_r == TAP_MAX) begin
            state_s = ST_FAIL;
          end else begin
            state_s = ST_SETTLE;
            tap_s   = tap_r + 1'b1;
            setl_s  = '0;
          end
        end else begin
          state_s = ST_DONE;
          lock_s  = tap_r;
          scnt_s  = '0;
          ecnt_s  = '0;
`ifdef DLINE_TRACK_EN
          trk_s   = '0;
`endif
        end
      end
      ST_DONE: begin
        if (cal_start) begin
          state_s = ST_SETTLE;
          tap_s   = TAP_START;
          setl_s  = '0;
        end else begin
`ifdef DLINE_TRACK_EN
          // Tracking: only unanimous windows move the tap, then the line re-settles
          if (trk_r != '0) begin
            trk_s = trk_r - 1'b1;
          end else if (scnt_r == NSAMP_V) begin
            scnt_s = '0;
            ecnt_s = '0;
            if ((ecnt_r == NSAMP_V) && (tap_r != TAP_MAX)) begin
              tap_s  = tap_r + 1'b1;
              lock_s = tap_r + 1'b1;
              trk_s  = SETTLE_V;
            end else if ((ecnt_r == '0) && (tap_r != '0)) begin
              tap_s  = tap_r - 1'b1;
              lock_s = tap_r - 1'b1;
              trk_s  = SETTLE_V;
            end else begin
              tap_s  = tap_r;
            end
          end else if (pd_valid) begin
            scnt_s = scnt_r + 1'b1;
            ecnt_s = ecnt_r + SN_W'(pd_early);
          end else begin
            scnt_s = scnt_r;
          end
`else
          state_s = ST_DONE;
`endif
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, counter and registered-output update
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      tap_r   <= TAP_START;
      lock_r  <= '0;
      setl_r  <= '0;
      scnt_r  <= '0;
      ecnt_r  <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      fail_r  <= 1'b0;
`ifdef DLINE_TRACK_EN
      trk_r   <= '0;
`endif
    end else begin
      state_r <= state_s;
      tap_r   <= tap_s;
      lock_r  <= lock_s;
      setl_r  <= setl_s;
      scnt_r  <= scnt_s;
      ecnt_r  <= ecnt_s;
      busy_r  <= (state_s == ST_SETTLE) || (state_s == ST_SAMPLE) || (state_s == ST_STEP);
      done_r  <= (state_s == ST_DONE);
      fail_r  <= (state_s == ST_FAIL);
`ifdef DLINE_TRACK_EN
      trk_r   <= trk_s;
`endif
    end
  end

  assign tap_sel  = tap_r;
  assign lock_tap = lock_r;
  assign cal_busy = busy_r;
  assign cal_done = done_r;
  assign cal_fail = fail_r;

endmodule

// File: tb/tb_dline_tap_ctrl.sv
// Self-checking bench for dline_tap_ctrl: per-scenario tasks against a threshold/latency
// model of the calibration sweep, with randomized phase-detector stimulus.
`timescale 1ns/1ps
module tb_dline_tap_ctrl;
  localparam int TAP_W      = 5;
  localparam int SETTLE_CYC = 8;
  localparam int NSAMP      = 7;
  localparam int START_TAP  = 0;
  localparam int PER_TAP    = SETTLE_CYC + NSAMP + 2;
  localparam int NTAPS      = 1 << TAP_W;

  logic clk = 1'b0;
  logic reset, cal_start, pd_valid, pd_early;
  logic [TAP_W-1:0] tap_sel, lock_tap;
  logic cal_busy, cal_done, cal_fail;

  int tests = 0;
  int fails = 0;
  int last_lock = 0;

  dline_tap_ctrl #(.TAP_W(TAP_W), .SETTLE_CYC(SETTLE_CYC), .NSAMP(NSAMP), .START_TAP(START_TAP)) dut (
    .clk(clk), .reset(reset), .cal_start(cal_start), .pd_valid(pd_valid), .pd_early(pd_early),
    .tap_sel(tap_sel), .cal_busy(cal_busy), .cal_done(cal_done), .cal_fail(cal_fail), .lock_tap(lock_tap)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Majority rule from the vote definition: strictly more than half early.
  function automatic bit maj_early(input logic [6:0] pat);
    return $countones(pat) > (NSAMP / 2);
  endfunction

  // Runs one calibration. pd_early = (tap < thr); at tap ptap a 7-sample pattern is played after
  // a 10-cycle quiet period. Returns cycles from cal_start edge to done/fail (-1 on timeout).
  task automatic run_cal(input int thr, input int ptap, input logic [6:0] pat,
                         input int stall_at, input int stall_len, input int restart_at,
                         input bit rand_valid, output int ncyc, output int ndec);
    int pidx = 0;
    int prev;
    ndec = 0;
    ncyc = -1;
    cal_start = 1'b1; pd_valid = 1'b0; pd_early = 1'b0;
    tick();
    cal_start = 1'b0;
    prev = int'(tap_sel);
    for (int n = 1; n <= 1000; n++) begin
      if (ptap >= 0 && int'(tap_sel) == ptap) begin
        pd_valid = (pidx >= 10 && pidx < 17);
        pd_early = (pidx >= 10 && pidx < 17) ? pat[16 - pidx] : 1'b0;
        pidx++;
      end else begin
        pd_valid = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
        pd_early = (int'(tap_sel) < thr);
      end
      if (n >= stall_at && n < stall_at + stall_len) pd_valid = 1'b0;
      cal_start = (n == restart_at);
      tick();
      if (int'(tap_sel) < prev) ndec++;
      prev = int'(tap_sel);
      if (cal_done || cal_fail) begin
        ncyc = n;
        break;
      end
    end
    cal_start = 1'b0; pd_valid = 1'b0; pd_early = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cal_start = 1'($urandom_range(0, 1));
      pd_valid  = 1'($urandom_range(0, 1));
      pd_early  = 1'($urandom_range(0, 1));
      tick();
    end
    reset = 1'b0; cal_start = 1'b0; pd_valid = 1'b0; pd_early = 1'b0;
    tick();
    tests++; if (tap_sel !== TAP_W'(START_TAP)) begin fails++; $display("FAIL reset_tap: got %0d want %0d", tap_sel, START_TAP); end
    tests++; if (lock_tap !== '0) begin fails++; $display("FAIL reset_lock: got %0d want 0", lock_tap); end
    tests++; if (cal_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", cal_busy); end
    tests++; if (cal_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", cal_done); end
    tests++; if (cal_fail !== 1'b0) begin fails++; $display("FAIL reset_fail: got %b want 0", cal_fail); end
  endtask

  task automatic test_normal_lock();
    int n, d;
    run_cal(13, -1, 7'd0, 0, 0, -1, 1'b0, n, d);
    tests++; if (n < 14 * PER_TAP - 1 || n > 14 * PER_TAP + 1) begin fails++; $display("FAIL lock_latency: got %0d want %0d+-1", n, 14 * PER_TAP); end
    tests++; if (cal_done !== 1'b1 || lock_tap !== 5'd13) begin fails++; $display("FAIL lock_tap: got done=%b tap=%0d want done=1 tap=13", cal_done, lock_tap); end
    tests++; if (d !== 0) begin fails++; $display("FAIL lock_monotonic: got %0d decreases want 0", d); end
    last_lock = 13;
  endtask

  task automatic test_majority();
    int n, d;
    logic [6:0] pats [2];
    pats[0] = 7'b1010100;
    pats[1] = 7'b1101010;
    for (int k = 0; k < 2; k++) begin
      int exp_lock;
      exp_lock = maj_early(pats[k]) ? 5 : 4;
      run_cal(5, 4, pats[k], 0, 0, -1, 1'b0, n, d);
      tests++; if (n < 0 || cal_done !== 1'b1 || int'(lock_tap) != exp_lock) begin
        fails++; $display("FAIL majority_%0d: got done=%b lock=%0d want done=1 lock=%0d", k, cal_done, lock_tap, exp_lock);
      end
      last_lock = exp_lock;
    end
  endtask

  task automatic test_fail_sat();
    int n, d;
    run_cal(100, -1, 7'd0, 0, 0, -1, 1'b0, n, d);
    tests++; if (n != NTAPS * PER_TAP) begin fails++; $display("FAIL fail_latency: got %0d want %0d", n, NTAPS * PER_TAP); end
    tests++; if (cal_fail !== 1'b1 || cal_done !== 1'b0 || tap_sel !== 5'd31) begin
      fails++; $display("FAIL fail_state: got fail=%b done=%b tap=%0d want 1 0 31", cal_fail, cal_done, tap_sel);
    end
    tests++; if (d !== 0) begin fails++; $display("FAIL fail_nowrap: got %0d decreases want 0", d); end
    tests++; if (int'(lock_tap) != last_lock) begin fails++; $display("FAIL fail_lock_hold: got %0d want %0d", lock_tap, last_lock); end
    pd_valid = 1'b1; pd_early = 1'b1;
    repeat (5) tick();
    tests++; if (tap_sel !== 5'd31 || cal_fail !== 1'b1) begin fails++; $display("FAIL fail_hold: got tap=%0d fail=%b want 31 1", tap_sel, cal_fail); end
    cal_start = 1'b1; pd_valid = 1'b0;
    tick();
    cal_start = 1'b0;
    tests++; if (tap_sel !== 5'd0 || cal_fail !== 1'b0 || cal_busy !== 1'b1) begin
      fails++; $display("FAIL fail_restart: got tap=%0d fail=%b busy=%b want 0 0 1", tap_sel, cal_fail, cal_busy);
    end
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      pd_valid = 1'b1; pd_early = 1'b0;
      tick();
      if (cal_done) begin n = i; break; end
    end
    pd_valid = 1'b0;
    tests++; if (n != PER_TAP || lock_tap !== 5'd0) begin fails++; $display("FAIL restart_lock: got cyc=%0d lock=%0d want %0d 0", n, lock_tap, PER_TAP); end
    last_lock = 0;
  endtask

  task automatic test_stall();
    int n, d;
    run_cal(2, -1, 7'd0, 11, 20, -1, 1'b0, n, d);
    tests++; if (n != 3 * PER_TAP + 20 || lock_tap !== 5'd2) begin
      fails++; $display("FAIL stall: got cyc=%0d lock=%0d want %0d 2", n, lock_tap, 3 * PER_TAP + 20);
    end
    last_lock = 2;
  endtask

  task automatic test_start_ignored();
    int n, d;
    run_cal(3, -1, 7'd0, 0, 0, 12, 1'b0, n, d);
    tests++; if (n != 4 * PER_TAP || lock_tap !== 5'd3) begin
      fails++; $display("FAIL start_in_sample: got cyc=%0d lock=%0d want %0d 3", n, lock_tap, 4 * PER_TAP);
    end
    last_lock = 3;
  endtask

  task automatic test_abort();
    bit hit = 1'b0;
    cal_start = 1'b1; tick(); cal_start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      pd_valid = 1'b1; pd_early = 1'b1;
      tick();
      if (tap_sel == 5'd9) begin hit = 1'b1; break; end
    end
    tests++; if (!hit) begin fails++; $display("FAIL abort_reach9: got tap=%0d want 9", tap_sel); end
    repeat (3) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    tests++; if (tap_sel !== 5'd0 || lock_tap !== 5'd0 || cal_busy !== 1'b0 || cal_done !== 1'b0 || cal_fail !== 1'b0) begin
      fails++; $display("FAIL abort_reset: got tap=%0d lock=%0d busy=%b done=%b fail=%b want 0 0 0 0 0", tap_sel, lock_tap, cal_busy, cal_done, cal_fail);
    end
    repeat (40) tick();
    tests++; if (tap_sel !== 5'd0 || cal_busy !== 1'b0) begin fails++; $display("FAIL abort_idle: got tap=%0d busy=%b want 0 0", tap_sel, cal_busy); end
    pd_valid = 1'b0; pd_early = 1'b0;
    last_lock = 0;
  endtask

  task automatic test_random();
    int n, d, thr, exp_tap;
    for (int k = 0; k < 6; k++) begin
      thr = $urandom_range(0, 36);
      exp_tap = (thr < NTAPS) ? thr : NTAPS - 1;
      run_cal(thr, -1, 7'd0, 0, 0, -1, 1'b1, n, d);
      if (thr < NTAPS) last_lock = thr;
      tests++; if (n < (exp_tap + 1) * PER_TAP || cal_done !== (thr < NTAPS) || cal_fail !== (thr >= NTAPS)
                   || int'(tap_sel) != exp_tap || int'(lock_tap) != last_lock || d != 0) begin
        fails++; $display("FAIL random_%0d thr=%0d: got cyc=%0d done=%b fail=%b tap=%0d lock=%0d dec=%0d want tap=%0d lock=%0d",
                          k, thr, n, cal_done, cal_fail, tap_sel, lock_tap, d, exp_tap, last_lock);
      end
    end
  endtask

`ifdef DLINE_TRACK_EN
  task automatic test_tracking();
    int n, d, moved;
    logic [6:0] mix;
    mix = 7'b1101010;
    run_cal(13, -1, 7'd0, 0, 0, -1, 1'b0, n, d);
    tests++; if (lock_tap !== 5'd13 || cal_done !== 1'b1) begin fails++; $display("FAIL trk_lock: got %0d want 13", lock_tap); end
    for (int i = 0; i < NSAMP; i++) begin pd_valid = 1'b1; pd_early = 1'b1; tick(); end
    pd_valid = 1'b0; tick();
    tests++; if (tap_sel !== 5'd14 || lock_tap !== 5'd14 || cal_done !== 1'b1) begin
      fails++; $display("FAIL trk_up: got tap=%0d lock=%0d done=%b want 14 14 1", tap_sel, lock_tap, cal_done);
    end
    for (int i = 0; i < SETTLE_CYC; i++) begin pd_valid = 1'b1; pd_early = 1'b0; tick(); end
    for (int i = 0; i < NSAMP; i++) begin pd_valid = 1'b1; pd_early = mix[6 - i]; tick(); end
    pd_valid = 1'b0; tick();
    tests++; if (tap_sel !== 5'd14) begin fails++; $display("FAIL trk_mixed: got %0d want 14", tap_sel); end
    for (int i = 0; i < NSAMP; i++) begin pd_valid = 1'b1; pd_early = 1'b0; tick(); end
    pd_valid = 1'b0; tick();
    tests++; if (tap_sel !== 5'd13 || lock_tap !== 5'd13) begin fails++; $display("FAIL trk_down: got tap=%0d lock=%0d want 13 13", tap_sel, lock_tap); end
    pd_valid = 1'b1; pd_early = 1'b0;
    repeat (13 * (SETTLE_CYC + NSAMP + 1) - 1) tick();
    tests++; if (tap_sel !== 5'd1) begin fails++; $display("FAIL trk_descend_timing: got %0d want 1", tap_sel); end
    tick();
    tests++; if (tap_sel !== 5'd0) begin fails++; $display("FAIL trk_descend: got %0d want 0", tap_sel); end
    moved = 0;
    repeat (48) begin tick(); if (tap_sel !== 5'd0 || cal_done !== 1'b1) moved++; end
    tests++; if (moved != 0) begin fails++; $display("FAIL trk_floor: got %0d bad cycles want 0", moved); end
    pd_valid = 1'b0; pd_early = 1'b0;
    last_lock = 0;
  endtask
`else
  task automatic test_static_done();
    int n, d, moved;
    run_cal(7, -1, 7'd0, 0, 0, -1, 1'b0, n, d);
    moved = 0;
    repeat (100) begin
      pd_valid = 1'($urandom_range(0, 1));
      pd_early = 1'($urandom_range(0, 1));
      tick();
      if (tap_sel !== 5'd7 || lock_tap !== 5'd7 || cal_done !== 1'b1) moved++;
    end
    tests++; if (moved != 0) begin fails++; $display("FAIL static_done: got %0d changed cycles want 0", moved); end
    pd_valid = 1'b0; pd_early = 1'b0;
    last_lock = 7;
  endtask
`endif

  initial begin
    reset = 1'b1; cal_start = 1'b0; pd_valid = 1'b0; pd_early = 1'b0;
    test_reset();
    test_normal_lock();
    test_majority();
    test_fail_sat();
    test_stall();
    test_start_ignored();
    test_abort();
    test_random();
`ifdef DLINE_TRACK_EN
    test_tracking();
`else
    test_static_done();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dline_tap_ctrl.md
Name: dline_tap_ctrl

Overview:
- Calibration and tracking controller for a digitally controlled delay line built from a chain of standard-cell buffers (BUFx2/HB-class cells), with a tap mux selecting the output.
- Sweeps the tap select upward, waits for the line to settle, majority-votes phase-detector samples, and locks on the first tap at which the delayed edge is no longer early.
- Sits between the clock-alignment phase detector and the delay-line tap mux. Calibration is started by software or reset-sequencing logic.

Parameters:
- TAP_W, 5, width of tap_sel; the line has 2**TAP_W taps.
- SETTLE_CYC, 8, clk cycles waited after every tap change before sampling (must be >= 1).
- NSAMP, 7, phase-detector samples per tap (odd, 1..15); majority decides.
- START_TAP, 0, tap loaded when a calibration starts.

Ports:
- clk, in, 1, single clock; all state updates on the rising edge.
- reset, in, 1, synchronous, active-high reset.
- cal_start, in, 1, one-cycle pulse; honoured only in IDLE, DONE or FAIL.
- pd_valid, in, 1, phase-detector sample valid this cycle.
- pd_early, in, 1, delayed edge leads the reference; qualified by pd_valid.
- tap_sel, out, TAP_W, delay-line tap select (registered).
- cal_busy, out, 1, high in SETTLE, SAMPLE and STEP.
- cal_done, out, 1, level; high while in DONE (locked).
- cal_fail, out, 1, level; high while in FAIL (no tap satisfied).
- lock_tap, out, TAP_W, tap captured at lock; holds its value until the next lock.

Behaviour:
- Reset state: FSM=IDLE, tap_sel=START_TAP, lock_tap=0, cal_busy=0, cal_done=0, cal_fail=0, all counters 0.
- Reset asserted mid-calibration aborts it on the same edge and returns all state to the reset values above.
- All outputs are registered. Flags reflect the state one cycle after the transition edge.
- State IDLE: on cal_start, tap_sel<=START_TAP, settle counter<=0, go to SETTLE.
- State SETTLE: count SETTLE_CYC cycles. pd inputs are ignored. Then clear the sample counter (scnt) and early counter (ecnt) and go to SAMPLE.
- State SAMPLE: on each cycle with pd_valid=1, scnt++ and ecnt += pd_early. Cycles with pd_valid=0 stall with no timeout. When scnt reaches NSAMP, go to STEP. The NSAMP-th sample itself is included in the vote.
- State STEP (one cycle): majority early means ecnt > NSAMP/2.
  - Majority early and tap_sel < 2**TAP_W-1: tap_sel++, go to SETTLE.
  - Majority early and tap_sel == max: go to FAIL. tap_sel holds at max and never wraps.
  - Otherwise: lock_tap<=tap_sel, go to DONE.
- States DONE and FAIL: hold all outputs. cal_start restarts from START_TAP exactly as from IDLE.
- cal_start outside IDLE, DONE or FAIL is ignored. It is not queued.
- Worst-case calibration latency is 2**TAP_W * (SETTLE_CYC + NSAMP + 2) cycles, with pd_valid continuously high.
- Counters are sized to $clog2(max value + 1). No arithmetic overflow is possible.

Optional Feature:
- Macro DLINE_TRACK_EN.
- When defined, DONE becomes a tracking state:
  - The controller keeps sampling in windows of NSAMP valid samples.
  - Unanimous early (ecnt == NSAMP) and tap_sel < max: tap_sel++.
  - Unanimous late (ecnt == 0) and tap_sel > 0: tap_sel--.
  - Mixed windows leave tap_sel unchanged (hysteresis).
  - After any tap change, wait SETTLE_CYC cycles before the next window.
  - lock_tap updates to each new tap_sel.
  - cal_done stays high throughout tracking.
- When undefined, DONE is static: no sampling and tap_sel frozen. Tracking logic and the extra counter are absent from the netlist.

Test Plan:
- Reset check: reset asserted 3 cycles with random inputs -> tap_sel=0, lock_tap=0, all flags 0 on the cycle after reset deasserts.
- Normal lock:
  - Setup: TAP_W=5, SETTLE_CYC=8, NSAMP=7, START_TAP=0, pd_valid=1; pd_early=1 while tap_sel<13, else 0.
  - Drive: cal_start.
  - Expect: cal_done=1 with lock_tap=13, after 14*(8+7+2)=238 cycles ±1, and tap_sel never decreases.
- Majority vote: at tap 4, drive pd_early pattern 1,0,1,0,1,0,0 (3 of 7 early) -> lock at 4. Repeat with pattern 1,1,0,1,0,1,0 (4 of 7 early) -> step to 5.
- Fail and saturation: pd_early held at 1 -> cal_fail=1 with tap_sel=31, no wrap to 0, cal_done=0. A cal_start then restarts at tap 0 with cal_fail cleared.
- Stall and abort:
  - pd_valid low for 20 cycles mid-SAMPLE -> scnt holds and the FSM stays in SAMPLE.
  - reset pulsed during SETTLE at tap 9 -> next cycle tap_sel=0, FSM IDLE.
  - cal_start during SAMPLE -> ignored.
- Tracking (DLINE_TRACK_EN defined), after lock at 13:
  - 7 early samples -> tap 14, then an 8-cycle settle.
  - Mixed 4/3 window -> stays at 14.
  - 7 late samples -> tap 13.
  - At tap 0, 7 late samples -> stays at 0.
